// File: rtl/alu_seq_exec.sv
// Sequential EX-stage ALU: single-cycle logical/arithmetic/compare/LUI ops,
// bit-serial SLL/SRL, valid/ready handshake on both the request and result sides.
module alu_seq_exec (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_ctr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_CMP = 4'b1111;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dir_right_q, dir_right_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        overflow_q, overflow_d;
    logic        illegal_q, illegal_d;

    logic        accept;
    logic        is_shift;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        alu_ill;
    logic [31:0] shift_next;

    assign accept   = in_valid && (state_q == IDLE);
    assign is_shift = (alu_ctr == OP_SLL) || (alu_ctr == OP_SRL);
    assign sum      = a + b;
    assign diff     = a - b;

    // One-bit step of the serial shifter, zero filled in the chosen direction.
    assign shift_next = dir_right_q ? {1'b0, shreg_q[31:1]} : {shreg_q[30:0], 1'b0};

    always_comb begin
        alu_res = 32'h0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctr)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OP_NOR: alu_res = ~(a | b);
            OP_SLT: alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_LUI: alu_res = {b[15:0], 16'h0000};
            OP_CMP: alu_res = a ^ b;
            OP_SLL, OP_SRL: alu_res = b;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= 32'h0;
            cnt_q       <= 5'd0;
            dir_right_q <= 1'b0;
            result_q    <= 32'h0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            dir_right_q <= dir_right_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != 5'd0)) state_d = SHIFT;
                    else                             state_d = DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == 5'd1) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result flags are only written on the transition into DONE so they stay stable while presented.
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        dir_right_d = dir_right_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift) begin
                        shreg_d     = b;
                        cnt_d       = shamt;
                        dir_right_d = (alu_ctr == OP_SRL);
                    end
                    if (!(is_shift && (shamt != 5'd0))) begin
                        result_d   = alu_res;
                        zero_d     = (alu_res == 32'h0);
                        overflow_d = alu_ovf;
                        illegal_d  = alu_ill;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shift_next;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d   = shift_next;
                    zero_d     = (shift_next == 32'h0);
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule
